// File: rtl/data_mem_resp.sv
// data_mem_resp
//   Responder end of the CPU data-memory bus. Serves a word-addressed data RAM
//   and a four-register memory-mapped timer whose pending flag drives the CPU
//   interrupt line. Reads are combinational; writes commit on the rising edge.
//
// Ports
//   clk       in   1   system clock, rising edge
//   n_rst     in   1   asynchronous active-low reset
//   MA        in   32  byte address; MA[1:0] ignored
//   MWD       in   32  write data
//   MWR       in   1   write strobe
//   MOE       in   1   read enable
//   MRD       out  32  read data, combinational from MA/MOE
//   IRQ       out  1   level interrupt = PEND & IE
//   ADDR_ERR  out  1   one-cycle pulse after an access to an unmapped address
//
// Timer map (offset = MA[3:2])
//   0x0 TCNT   0x4 TCMP   0x8 TCTRL {AUTO,IE,EN}   0xC TSTAT {PEND}, write-1-to-clear
module data_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] MA,
  input  logic [31:0] MWD,
  input  logic        MWR,
  input  logic        MOE,
  output logic [31:0] MRD,
  output logic        IRQ,
  output logic        ADDR_ERR
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    REG_TCNT  = 2'd0,
    REG_TCMP  = 2'd1,
    REG_TCTRL = 2'd2,
    REG_TSTAT = 2'd3
  } reg_sel_e;

  logic [31:0] mem [DEPTH_WORDS];

  logic          ram_sel;
  logic          mmio_sel;
  logic          unmapped;
  logic [AW-1:0] ram_idx;
  reg_sel_e      reg_sel;

  logic [31:0] tcnt;
  logic [31:0] tcmp;
  logic        t_en;
  logic        t_ie;
  logic        t_auto;
  logic        pend;

  logic        hit;
  logic        wr_tcnt;
  logic        wr_tcmp;
  logic        wr_tctrl;
  logic        wr_tstat;

  // Address decode
  always_comb begin
    ram_sel  = ({1'b0, MA} < RAM_LIMIT);
    mmio_sel = (MA[31:4] == MMIO_BASE[31:4]);
    unmapped = !ram_sel && !mmio_sel;
    ram_idx  = MA[AW+1:2];
    reg_sel  = reg_sel_e'(MA[3:2]);
  end

  always_comb begin
    wr_tcnt  = MWR && mmio_sel && (reg_sel == REG_TCNT);
    wr_tcmp  = MWR && mmio_sel && (reg_sel == REG_TCMP);
    wr_tctrl = MWR && mmio_sel && (reg_sel == REG_TCTRL);
    wr_tstat = MWR && mmio_sel && (reg_sel == REG_TSTAT);
    // Compare uses the current register values; a CPU write this cycle only
    // affects the compare from the next edge.
    hit      = t_en && (tcnt == tcmp);
  end

  // RAM: no reset, contents survive n_rst
  always_ff @(posedge clk) begin
    if (MWR && ram_sel) begin
      mem[ram_idx] <= MWD;
    end
  end

  // Read mux; a same-cycle write is not yet visible, so the old value is returned
  always_comb begin
    MRD = '0;
    if (MOE) begin
      if (ram_sel) begin
        MRD = mem[ram_idx];
      end else if (mmio_sel) begin
        unique case (reg_sel)
          REG_TCNT:  MRD = tcnt;
          REG_TCMP:  MRD = tcmp;
          REG_TCTRL: MRD = {29'd0, t_auto, t_ie, t_en};
          REG_TSTAT: MRD = {31'd0, pend};
          default:   MRD = '0;
        endcase
      end
    end
  end

  // Counter: CPU write beats increment/reload
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tcnt <= '0;
    end else if (wr_tcnt) begin
      tcnt <= MWD;
    end else if (t_en) begin
      tcnt <= (hit && t_auto) ? '0 : tcnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tcmp   <= '1;
      t_en   <= 1'b0;
      t_ie   <= 1'b0;
      t_auto <= 1'b0;
    end else begin
      if (wr_tcmp) begin
        tcmp <= MWD;
      end
      if (wr_tctrl) begin
        t_en   <= MWD[0];
        t_ie   <= MWD[1];
        t_auto <= MWD[2];
      end
    end
  end

  // Pending flag: a hit in the same cycle as a write-1-to-clear keeps PEND set
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend <= 1'b0;
    end else if (hit) begin
      pend <= 1'b1;
    end else if (wr_tstat && MWD[0]) begin
      pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ADDR_ERR <= 1'b0;
    end else begin
      ADDR_ERR <= (MWR || MOE) && unmapped;
    end
  end

  // Both terms are flops, so IRQ cannot glitch on bus activity
  assign IRQ = pend && t_ie;

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] MA, MWD, MRD;
  logic        MWR, MOE, IRQ, ADDR_ERR;

  data_mem_resp #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk(clk), .n_rst(n_rst), .MA(MA), .MWD(MWD), .MWR(MWR), .MOE(MOE),
    .MRD(MRD), .IRQ(IRQ), .ADDR_ERR(ADDR_ERR)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_ram [DEPTH];
  bit          m_vld [DEPTH];
  logic [31:0] m_cnt, m_cmp;
  logic [2:0]  m_ctrl;
  logic        m_pend, m_aerr;

  // Values sampled during the most recent cycle
  logic [31:0] s_rd;
  logic        s_irq, s_aerr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_ram(input logic [31:0] a);
    return a < DEPTH * 4;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a & 32'hFFFF_FFF0) == (BASE & 32'hFFFF_FFF0);
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_cmp  = 32'hFFFF_FFFF;
    m_ctrl = 0;
    m_pend = 0;
    m_aerr = 0;
  endtask

  // Expected MRD; returns 0 in 'known' when the RAM word was never written
  function automatic logic [31:0] model_read(input logic [31:0] a, input logic oe, output bit known);
    int unsigned w;
    known = 1;
    if (!oe) return 0;
    if (is_ram(a)) begin
      w = a / 4;
      known = m_vld[w];
      return m_ram[w];
    end
    if (is_mmio(a)) begin
      case ((a / 4) % 4)
        0: return m_cnt;
        1: return m_cmp;
        2: return {29'd0, m_ctrl};
        default: return {31'd0, m_pend};
      endcase
    end
    return 0;
  endfunction

  // Apply one clock edge to the model using the bus values currently driven
  task automatic model_edge();
    bit          hit;
    logic [31:0] ncnt;
    logic        npend;
    hit   = m_ctrl[0] && (m_cnt == m_cmp);
    ncnt  = m_cnt;
    npend = m_pend || hit;
    if (m_ctrl[0]) ncnt = (hit && m_ctrl[2]) ? 32'd0 : m_cnt + 32'd1;
    if (MWR && is_ram(MA)) begin
      m_ram[MA / 4] = MWD;
      m_vld[MA / 4] = 1;
    end
    if (MWR && is_mmio(MA)) begin
      case ((MA / 4) % 4)
        0: ncnt = MWD;
        1: m_cmp = MWD;
        2: m_ctrl = MWD[2:0];
        default: if (MWD[0] && !hit) npend = 0;
      endcase
    end
    m_aerr = (MWR || MOE) && !is_ram(MA) && !is_mmio(MA);
    m_cnt  = ncnt;
    m_pend = npend;
  endtask

  // One bus cycle: starts 1 time unit after a rising edge, ends likewise
  task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic wr, input logic oe);
    logic [31:0] exp_rd;
    bit          known;
    MA = a; MWD = d; MWR = wr; MOE = oe;
    #3;
    s_rd = MRD; s_irq = IRQ; s_aerr = ADDR_ERR;
    exp_rd = model_read(a, oe, known);
    if (known) chk("MRD", s_rd, exp_rd);
    chk("IRQ", {31'd0, s_irq}, {31'd0, m_pend && m_ctrl[1]});
    chk("ADDR_ERR", {31'd0, s_aerr}, {31'd0, m_aerr});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(a, d, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(a, 32'd0, 1'b0, 1'b1);
  endtask

  localparam logic [31:0] A_TCNT  = BASE + 32'h0;
  localparam logic [31:0] A_TCMP  = BASE + 32'h4;
  localparam logic [31:0] A_TCTRL = BASE + 32'h8;
  localparam logic [31:0] A_TSTAT = BASE + 32'hC;

  initial begin
    logic [31:0] seq [6];
    logic        irqs [6];
    logic [31:0] a, d;
    int unsigned r;

    seq  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    irqs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset
    n_rst = 1'b0; MA = '0; MWD = '0; MWR = 1'b0; MOE = 1'b0;
    model_reset();
    #12;
    chk("rst_MRD", MRD, 32'd0);
    chk("rst_IRQ", {31'd0, IRQ}, 32'd0);
    chk("rst_ADDR_ERR", {31'd0, ADDR_ERR}, 32'd0);
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    rd(A_TCMP); chk("rst_TCMP", s_rd, 32'hFFFF_FFFF);
    rd(A_TCNT); chk("rst_TCNT", s_rd, 32'd0);

    // RAM
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10); chk("ram_rd10", s_rd, 32'hDEAD_BEEF);
    rd(32'h13); chk("ram_rd13", s_rd, 32'hDEAD_BEEF);
    cycle(32'h10, 32'hCAFE_F00D, 1'b1, 1'b1); chk("ram_rw_old", s_rd, 32'hDEAD_BEEF);
    rd(32'h10); chk("ram_rw_new", s_rd, 32'hCAFE_F00D);

    // Auto-reload
    wr(A_TCNT, 32'd0);
    wr(A_TCMP, 32'd3);
    wr(A_TCTRL, 32'd7);
    for (int i = 0; i < 6; i++) begin
      rd(A_TCNT);
      chk("auto_tcnt", s_rd, seq[i]);
      chk("auto_irq", {31'd0, s_irq}, {31'd0, irqs[i]});
    end
    wr(A_TSTAT, 32'd1);
    rd(A_TCNT); chk("w1c_irq", {31'd0, s_irq}, 32'd0);

    // Wrap without reload; IE off keeps IRQ low
    wr(A_TCTRL, 32'd0);
    wr(A_TSTAT, 32'd1);
    wr(A_TCNT, 32'hFFFF_FFFE);
    wr(A_TCMP, 32'hFFFF_FFFF);
    wr(A_TCTRL, 32'hFFFF_FFF9);  // upper bits ignored, only EN lands
    rd(A_TCNT);  chk("wrap_fffe", s_rd, 32'hFFFF_FFFE);
    rd(A_TCNT);  chk("wrap_ffff", s_rd, 32'hFFFF_FFFF);
    rd(A_TCNT);  chk("wrap_zero", s_rd, 32'd0);
    rd(A_TSTAT); chk("wrap_pend", s_rd, 32'd1);
    chk("wrap_irq", {31'd0, s_irq}, 32'd0);
    rd(A_TCTRL); chk("tctrl_mask", s_rd, 32'd1);

    // Hit coincident with W1C; TCNT write while counting
    wr(A_TCTRL, 32'd0);
    wr(A_TSTAT, 32'd1);
    rd(A_TSTAT); chk("pend_clr", s_rd, 32'd0);
    wr(A_TCMP, 32'd5);
    wr(A_TCNT, 32'd5);
    wr(A_TCTRL, 32'd1);
    wr(A_TSTAT, 32'd1);
    rd(A_TSTAT); chk("hit_beats_w1c", s_rd, 32'd1);
    wr(A_TCNT, 32'h100);
    rd(A_TCNT); chk("tcnt_wr_wins", s_rd, 32'h100);

    // Unmapped accesses
    wr(32'h0, 32'h1234_5678);
    cycle(32'h8000_0000, 32'hBAD0_BAD0, 1'b1, 1'b0);
    chk("bad_mrd", s_rd, 32'd0);
    chk("bad_aerr_same", {31'd0, s_aerr}, 32'd0);
    rd(32'h0);
    chk("bad_aerr_pulse", {31'd0, s_aerr}, 32'd1);
    chk("ram_untouched", s_rd, 32'h1234_5678);
    rd(32'h0); chk("bad_aerr_end", {31'd0, s_aerr}, 32'd0);
    rd(32'h8000_0000); chk("bad_rd_mrd", s_rd, 32'd0);
    rd(DEPTH * 4);
    chk("b2b_aerr1", {31'd0, s_aerr}, 32'd1);
    rd(32'h10);
    chk("b2b_aerr2", {31'd0, s_aerr}, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      a = ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
      else if (r < 8) a = BASE + $urandom_range(0, 15);
      else if (r < 9) a = (DEPTH * 4) + $urandom_range(0, 32'h0FFF_FFFF);
      else            a = BASE - 32'd4 + $urandom_range(0, 3) * 32'd20;
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 24));
      cycle(a, d, ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 7));
    end

    // Async reset with IRQ high
    wr(A_TCTRL, 32'd0);
    wr(A_TCNT, 32'd0);
    wr(A_TCMP, 32'd2);
    wr(A_TCTRL, 32'd3);
    for (int i = 0; i < 5; i++) rd(A_TCNT);
    chk("pre_rst_irq", {31'd0, s_irq}, 32'd1);
    MWR = 1'b0; MOE = 1'b0;
    #1 n_rst = 1'b0;
    #1;
    model_reset();
    chk("async_irq", {31'd0, IRQ}, 32'd0);
    chk("async_aerr", {31'd0, ADDR_ERR}, 32'd0);
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    rd(A_TCMP); chk("post_rst_tcmp", s_rd, 32'hFFFF_FFFF);
    rd(A_TCNT); chk("post_rst_tcnt", s_rd, 32'd0);
    rd(32'h10); chk("ram_keeps", s_rd, m_ram[4]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
